// File: rtl/jk_counter_bank.sv
// Bank of WIDTH JK flip-flops that can also act as a modulo-MOD up/down counter
// or a parallel-load register, with wrap and clamp event pulses.
module jk_counter_bank #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qb_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             err_o
);

  // The modulus may equal 2^WIDTH, so range checks are done one bit wider than the register.
  localparam logic [WIDTH:0]   MOD_C  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             ovf_r;
  logic             err_r;
  logic             ovf_next_s;
  logic             err_next_s;

  // Next-state and event selection for the currently requested operation.
  always_comb begin
    q_next_s   = q_r;
    ovf_next_s = 1'b0;
    err_next_s = 1'b0;
    if (en_i) begin
      case (mode_i)
        MODE_JK: begin
          // Characteristic equation Q+ = J&~Q | ~K&Q, applied bitwise.
          q_next_s = (j_i & ~q_r) | (~k_i & q_r);
        end
        MODE_UP: begin
          if (q_r >= MAX_C) begin
            q_next_s   = ZERO_C;
            ovf_next_s = 1'b1;
          end else begin
            q_next_s = q_r + ONE_C;
          end
        end
        MODE_DOWN: begin
          if (q_r == ZERO_C) begin
            q_next_s   = MAX_C;
            ovf_next_s = 1'b1;
          end else if ({1'b0, q_r} >= MOD_C) begin
            q_next_s = MAX_C;
          end else begin
            q_next_s = q_r - ONE_C;
          end
        end
        MODE_LOAD: begin
          if ({1'b0, d_i} < MOD_C) begin
            q_next_s = d_i;
          end else begin
            q_next_s   = MAX_C;
            err_next_s = 1'b1;
          end
        end
        default: begin
          q_next_s = q_r;
        end
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // State and event-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r   <= ZERO_C;
      ovf_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next_s;
      ovf_r <= ovf_next_s;
      err_r <= err_next_s;
    end
  end

  // Terminal count looks at the live mode so it is valid even while held.
  always_comb begin
    if (mode_i == MODE_UP) begin
      tc_o = (q_r == MAX_C);
    end else if (mode_i == MODE_DOWN) begin
      tc_o = (q_r == ZERO_C);
    end else begin
      tc_o = 1'b0;
    end
  end

  assign q_o   = q_r;
  assign qb_o  = ~q_r;
  assign ovf_o = ovf_r;
  assign err_o = err_r;

endmodule

// File: tb/tb_jk_counter_bank.sv
// Self-checking bench for jk_counter_bank (WIDTH=4, MOD=10): directed scenarios
// with literal expectations plus randomized traffic against an integer model.
module tb_jk_counter_bank;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             en_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] j_i;
  logic [WIDTH-1:0] k_i;
  logic [WIDTH-1:0] d_i;
  logic [WIDTH-1:0] q_o;
  logic [WIDTH-1:0] qb_o;
  logic             tc_o;
  logic             ovf_o;
  logic             err_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_q   = 0;
  int m_ovf = 0;
  int m_err = 0;
  bit started = 1'b0;

  jk_counter_bank #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .mode_i(mode_i),
    .j_i(j_i), .k_i(k_i), .d_i(d_i),
    .q_o(q_o), .qb_o(qb_o), .tc_o(tc_o), .ovf_o(ovf_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the mode rules.
  always @(posedge clk) begin : model
    int nq;
    int no;
    int ne;
    nq = m_q;
    no = 0;
    ne = 0;
    if (reset) begin
      nq = 0;
      started <= 1'b1;
    end else if (en_i) begin
      case (mode_i)
        2'd0: begin
          nq = 0;
          for (int b = 0; b < WIDTH; b++) begin
            int qb;
            qb = (m_q >> b) & 1;
            case ({j_i[b], k_i[b]})
              2'b00: qb = qb;
              2'b01: qb = 0;
              2'b10: qb = 1;
              default: qb = 1 - qb;
            endcase
            nq = nq + (qb << b);
          end
        end
        2'd1: begin
          if (m_q >= MOD - 1) begin nq = 0; no = 1; end
          else nq = m_q + 1;
        end
        2'd2: begin
          if (m_q == 0) begin nq = MOD - 1; no = 1; end
          else if (m_q >= MOD) nq = MOD - 1;
          else nq = m_q - 1;
        end
        default: begin
          if (int'(d_i) < MOD) nq = int'(d_i);
          else begin nq = MOD - 1; ne = 1; end
        end
      endcase
    end
    m_q   <= nq;
    m_ovf <= no;
    m_err <= ne;
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      int m_tc;
      m_tc = ((mode_i == 2'd1 && m_q == MOD - 1) || (mode_i == 2'd2 && m_q == 0)) ? 1 : 0;
      chk("q_model",   int'(q_o),   m_q);
      chk("qb_model",  int'(qb_o),  15 - m_q);
      chk("tc_model",  int'(tc_o),  m_tc);
      chk("ovf_model", int'(ovf_o), m_ovf);
      chk("err_model", int'(err_o), m_err);
    end
  end

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] j, input logic [3:0] k, input logic [3:0] d);
    reset  = r;
    en_i   = e;
    mode_i = m;
    j_i    = j;
    k_i    = k;
    d_i    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1'b1, 1'b1, 2'd1, 4'hF, 4'hF, 4'hF);
    step(1'b1, 1'b0, 2'd3, 4'h0, 4'h0, 4'hC);
    chk("reset_q", int'(q_o), 0);
    chk("reset_qb", int'(qb_o), 15);
    chk("reset_ovf", int'(ovf_o), 0);

    // JK set, then toggle twice.
    step(1'b0, 1'b1, 2'd0, 4'hF, 4'h0, 4'h0);
    chk("jk_set", int'(q_o), 15);
    chk("jk_set_qb", int'(qb_o), 0);
    step(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 4'h0);
    chk("jk_tog1", int'(q_o), 0);
    step(1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 4'h0);
    chk("jk_tog2", int'(q_o), 15);
    step(1'b0, 1'b1, 2'd0, 4'b0101, 4'b1010, 4'h0);
    chk("jk_mixed", int'(q_o), 5);

    // Count up from 0 for 12 edges.
    step(1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
      chk("up_q", int'(q_o), i % 10);
      chk("up_ovf", int'(ovf_o), (i == 10) ? 1 : 0);
      chk("up_tc", int'(tc_o), (i == 9) ? 1 : 0);
    end

    // Count down wrap, then down from out-of-range value.
    step(1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0);
    chk("dn_tc0", int'(tc_o), 0);
    step(1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    chk("dn_wrap_q", int'(q_o), 9);
    chk("dn_wrap_ovf", int'(ovf_o), 1);
    step(1'b0, 1'b1, 2'd0, 4'hF, 4'h0, 4'h0);
    chk("dn_set_q", int'(q_o), 15);
    chk("dn_set_ovf", int'(ovf_o), 0);
    step(1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    chk("dn_clamp_q", int'(q_o), 9);
    chk("dn_clamp_ovf", int'(ovf_o), 0);
    step(1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    chk("dn_dec_q", int'(q_o), 8);

    // Parallel load in range and clamped.
    step(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'b0111);
    chk("ld_q", int'(q_o), 7);
    chk("ld_err", int'(err_o), 0);
    step(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'b1100);
    chk("ld_clamp_q", int'(q_o), 9);
    chk("ld_clamp_err", int'(err_o), 1);
    step(1'b0, 1'b0, 2'd3, 4'h0, 4'h0, 4'b1100);
    chk("ld_hold_err", int'(err_o), 0);
    chk("ld_hold_q", int'(q_o), 9);

    // Hold while in count-up at terminal count; tc still reported.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 4'h0);
      chk("hold_q", int'(q_o), 9);
      chk("hold_ovf", int'(ovf_o), 0);
      chk("hold_tc", int'(tc_o), 1);
    end

    // Reset level without an edge must not disturb outputs.
    reset = 1'b1;
    #2;
    chk("async_q", int'(q_o), 9);
    @(posedge clk);
    #1;
    chk("rst_mid_q", int'(q_o), 0);
    chk("rst_mid_ovf", int'(ovf_o), 0);
    step(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
    chk("resume_q", int'(q_o), 1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99, 0) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(99, 0) < 80) ? 1'b1 : 1'b0,
           2'($urandom_range(3, 0)),
           4'($urandom_range(15, 0)),
           4'($urandom_range(15, 0)),
           4'($urandom_range(15, 0)));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
